// File: rtl/vr_vc_converter_if.sv
// Handshake bundle between the valid/ready upstream and the valid/credit downstream.
// The slave modport is the converter's view; master is the environment driving it.
interface vr_vc_converter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_credit_i;

  modport slave (
    input  s_data_i,
    input  s_valid_i,
    output s_ready_o,
    output m_data_o,
    output m_valid_o,
    input  m_credit_i
  );

  modport master (
    output s_data_i,
    output s_valid_i,
    input  s_ready_o,
    input  m_data_o,
    input  m_valid_o,
    output m_credit_i
  );
endinterface

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit converter: a beat is forwarded only while the
// downstream has returned a buffer slot, one registered pulse per beat.
module vr_vc_converter #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  vr_vc_converter_if.slave                 bus,
  output logic [$clog2(CREDIT_NUM+1)-1:0]  credit_cnt_o,
  output logic                             credit_err_o
);
  localparam int CW = $clog2(CREDIT_NUM + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_NUM);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]         cnt;
  logic                  err;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ready;
  logic                  send;

  // Ready depends only on the counter so there is no combinational path from s_valid_i.
  assign ready = (cnt != '0);
  assign send  = bus.s_valid_i && ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      err     <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= send;
      if (send) begin
        data_q <= bus.s_data_i;
      end
      // A credit returned in the same cycle as a send cancels out.
      case ({bus.m_credit_i, send})
        2'b10: begin
          if (cnt == CNT_MAX) begin
            err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.s_ready_o = ready;
  assign bus.m_valid_o = valid_q;
  assign bus.m_data_o  = data_q;
  assign credit_cnt_o  = cnt;
  assign credit_err_o  = err;
endmodule

// File: tb/tb_vr_vc_converter.sv
// Table-driven bench for vr_vc_converter with a scoreboard queue of accepted beats.
module tb_vr_vc_converter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] credit_cnt_o;
  logic       credit_err_o;

  vr_vc_converter_if #(.DATA_WIDTH(8)) bus ();

  vr_vc_converter #(.DATA_WIDTH(8), .CREDIT_NUM(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       credit;
    logic       valid;
    logic [7:0] data;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_cnt;
    logic       exp_ready;
    logic       exp_err;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  logic       ready_exp = 1'b0;
  vec_t       vecs[24];

  function automatic vec_t mk(logic r, logic c, logic v, logic [7:0] d,
                              logic ev, logic [7:0] ed, logic [1:0] ec,
                              logic er, logic ee);
    vec_t x;
    x.rst_n = r; x.credit = c; x.valid = v; x.data = d;
    x.exp_valid = ev; x.exp_data = ed; x.exp_cnt = ec;
    x.exp_ready = er; x.exp_err = ee;
    return x;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n          = v.rst_n;
    bus.m_credit_i = v.credit;
    bus.s_valid_i  = v.valid;
    bus.s_data_i   = v.data;
    if (v.rst_n && v.valid && ready_exp) sb_q.push_back(v.data);
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    checkVal({tag, " m_valid"}, int'(bus.m_valid_o), int'(v.exp_valid));
    checkVal({tag, " m_data"}, int'(bus.m_data_o), int'(v.exp_data));
    checkVal({tag, " cnt"}, int'(credit_cnt_o), int'(v.exp_cnt));
    checkVal({tag, " s_ready"}, int'(bus.s_ready_o), int'(v.exp_ready));
    checkVal({tag, " err"}, int'(credit_err_o), int'(v.exp_err));
    if (bus.m_valid_o) begin
      if (sb_q.size() == 0) begin
        checkVal({tag, " sb_unexpected_beat"}, 1, 0);
      end else begin
        checkVal({tag, " sb_data"}, int'(bus.m_data_o), int'(sb_q.pop_front()));
      end
    end
    ready_exp = v.exp_ready;
  endtask

  task automatic runRow(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  initial begin
    bool_reached: begin end
  end

  initial begin
    bit reached;
    rst_n = 1'b0;
    bus.m_credit_i = 1'b0;
    bus.s_valid_i  = 1'b0;
    bus.s_data_i   = 8'h00;

    // reset (credits ignored), grant, single beat, exhaustion, simultaneous, overflow, mid-op reset
    vecs[0]  = mk(0, 1, 1, 8'h77, 0, 8'h00, 2'd0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 8'h11, 0, 8'h00, 2'd0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 2'd1, 1, 0);
    vecs[4]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 2'd2, 1, 0);
    vecs[5]  = mk(1, 0, 0, 8'h50, 0, 8'h00, 2'd2, 1, 0);
    vecs[6]  = mk(1, 0, 1, 8'hAA, 1, 8'hAA, 2'd1, 1, 0);
    vecs[7]  = mk(1, 0, 0, 8'h00, 0, 8'hAA, 2'd1, 1, 0);
    vecs[8]  = mk(1, 1, 0, 8'h00, 0, 8'hAA, 2'd2, 1, 0);
    vecs[9]  = mk(1, 0, 1, 8'hBB, 1, 8'hBB, 2'd1, 1, 0);
    vecs[10] = mk(1, 0, 1, 8'hCC, 1, 8'hCC, 2'd0, 0, 0);
    vecs[11] = mk(1, 0, 1, 8'hDD, 0, 8'hCC, 2'd0, 0, 0);
    vecs[12] = mk(1, 1, 1, 8'hDD, 0, 8'hCC, 2'd1, 1, 0);
    vecs[13] = mk(1, 0, 1, 8'hDD, 1, 8'hDD, 2'd0, 0, 0);
    vecs[14] = mk(1, 1, 0, 8'h00, 0, 8'hDD, 2'd1, 1, 0);
    vecs[15] = mk(1, 1, 1, 8'h55, 1, 8'h55, 2'd1, 1, 0);
    vecs[16] = mk(1, 0, 1, 8'h66, 1, 8'h66, 2'd0, 0, 0);
    vecs[17] = mk(1, 1, 0, 8'h00, 0, 8'h66, 2'd1, 1, 0);
    vecs[18] = mk(1, 1, 0, 8'h00, 0, 8'h66, 2'd2, 1, 0);
    vecs[19] = mk(1, 1, 0, 8'h00, 0, 8'h66, 2'd2, 1, 1);
    vecs[20] = mk(1, 0, 0, 8'h00, 0, 8'h66, 2'd2, 1, 1);
    vecs[21] = mk(1, 0, 1, 8'h77, 1, 8'h77, 2'd1, 1, 1);
    vecs[22] = mk(0, 1, 1, 8'h88, 0, 8'h00, 2'd0, 0, 0);
    vecs[23] = mk(1, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      runRow(vecs[i], $sformatf("vec%0d", i));
    end

    // s_ready must not follow s_valid combinationally while no credit is held
    @(negedge clk);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 8'h99;
    #1;
    checkVal("ready_no_valid_path", int'(bus.s_ready_o), 0);
    runRow(mk(1, 0, 1, 8'h99, 0, 8'h00, 2'd0, 0, 0), "starved");
    runRow(mk(1, 1, 0, 8'h00, 0, 8'h00, 2'd1, 1, 0), "grant1");

    // streaming at cnt==1 with a credit every cycle keeps the pipe full
    for (int i = 0; i < 4; i++) begin
      runRow(mk(1, 1, 1, 8'hA0 + 8'(i), 1, 8'hA0 + 8'(i), 2'd1, 1, 0),
             $sformatf("stream%0d", i));
    end
    runRow(mk(1, 0, 1, 8'hB0, 1, 8'hB0, 2'd0, 0, 0), "last_credit");

    // bounded wait for the counter to refill
    reached = 1'b0;
    for (int i = 0; i < 8 && !reached; i++) begin
      @(negedge clk);
      bus.s_valid_i  = 1'b0;
      bus.m_credit_i = 1'b1;
      @(posedge clk);
      #1;
      if (credit_cnt_o == 2'd2) reached = 1'b1;
    end
    checkVal("refill_within_bound", int'(reached), 1);
    @(negedge clk);
    bus.m_credit_i = 1'b0;

    checkVal("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vr_vc_converter.md
VR_VC_CONVERTER -- requirements
Module: vr_vc_converter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter CREDIT_NUM, default 2, giving the maximum credits held, equal to the downstream buffer depth; legal range is 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port s_data_i, input, DATA_WIDTH bits: upstream payload.
REQ-006 The block SHALL have port s_valid_i, input, 1 bit: upstream payload valid.
REQ-007 The block SHALL have port s_ready_o, output, 1 bit: the block can accept a beat this cycle.
REQ-008 The block SHALL have port m_data_o, output, DATA_WIDTH bits: downstream payload.
REQ-009 The block SHALL have port m_valid_o, output, 1 bit: a one-cycle pulse per transmitted beat.
REQ-010 The block SHALL have port m_credit_i, input, 1 bit: a one-cycle pulse, each returning one downstream buffer slot.
REQ-011 The block SHALL have port credit_cnt_o, output, $clog2(CREDIT_NUM+1) bits: current credit count.
REQ-012 The block SHALL have port credit_err_o, output, 1 bit: sticky credit-overflow flag.

Function
REQ-013 The credit counter cnt SHALL be $clog2(CREDIT_NUM+1) bits wide and start at 0 after reset.
- Credits are granted only by m_credit_i pulses from the downstream block.
- The downstream block grants CREDIT_NUM pulses after reset release.
REQ-014 s_ready_o SHALL equal (cnt != 0), decoded combinationally from the cnt register with no path from s_valid_i.
REQ-015 A transfer SHALL occur in any cycle with s_valid_i && s_ready_o.
REQ-016 On the edge ending a transfer cycle, the block SHALL register:
- m_data_o <= s_data_i;
- m_valid_o <= 1.
- Latency from transfer to m_valid_o high is exactly 1 cycle.
REQ-017 In a cycle with no transfer, the block SHALL register:
- m_valid_o <= 0;
- m_data_o keeps its last value.
REQ-018 The block SHALL update cnt each edge as cnt + credit_in - send, where send = transfer and credit_in = m_credit_i.
- Simultaneous send and credit leave cnt unchanged.
REQ-019 Back-to-back transfers SHALL be supported at 1 beat/cycle while cnt > 0.
- With cnt==1 and no same-cycle credit, the transfer takes the last credit and s_ready_o is 0 the next cycle.
REQ-020 When cnt==1, a transfer and a credit arrive in the same cycle, cnt SHALL stay 1 and s_ready_o SHALL stay high.
REQ-021 When m_credit_i is high with cnt==CREDIT_NUM and no send, cnt SHALL saturate at CREDIT_NUM and credit_err_o SHALL set.
- credit_err_o is cleared only by reset.
REQ-022 When cnt==0, the block SHALL keep m_valid_o at 0 whatever s_valid_i does, and no data SHALL be lost.
- The upstream holds s_data_i/s_valid_i until s_ready_o.
REQ-023 credit_cnt_o SHALL equal the cnt register.

Reset
REQ-024 While rst_n==0 at a rising edge, the block SHALL set cnt=0, m_valid_o=0, m_data_o=0 and credit_err_o=0.
- s_ready_o is therefore 0 in the cycle after that edge.
REQ-025 Reset asserted mid-operation SHALL discard all credits and any beat in flight.
- m_valid_o is 0 on the cycle after the reset edge.
- m_credit_i pulses during reset are ignored.
REQ-026 After reset release, the block SHALL accept no beat until at least one m_credit_i pulse has been received.

Verification
REQ-027 Credit grant: reset, then 2 m_credit_i pulses -> credit_cnt_o steps 0,1,2; s_ready_o rises the cycle after the first pulse.
REQ-028 Single beat: with cnt=2, drive s_data_i=8'hAA, s_valid_i=1 for one cycle -> next cycle m_valid_o=1, m_data_o=8'hAA, then cnt=1; the cycle after, m_valid_o=0 and m_data_o stays 8'hAA.
REQ-029 Exhaustion: with cnt=2 and no credits, hold s_valid_i=1 with 8'hBB, 8'hCC, 8'hDD -> only BB and CC are emitted on consecutive cycles; s_ready_o=0 while DD is held; one m_credit_i pulse -> DD is emitted 2 cycles after the pulse.
REQ-030 Simultaneous: with cnt=1, a transfer of 8'h55 and an m_credit_i pulse in the same cycle -> cnt stays 1, s_ready_o stays 1, and the next beat is accepted the following cycle.
REQ-031 Overflow: with cnt=2 and idle, pulse m_credit_i -> cnt stays 2, credit_err_o=1 and it remains 1 until rst_n=0.
REQ-032 Invalid data: with cnt=2, s_data_i=8'h50 and s_valid_i=0 -> m_valid_o stays 0, m_data_o is unchanged and cnt stays 2.
